// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//
// Pipelined RV32I instruction encoder: packs opcode, register indices, funct
// fields and a decoded (sign-extended, byte-offset) immediate into a 32-bit
// instruction word. Two register stages (A: field set, B: encoded word) with
// valid/ready handshakes on both sides and full throughput.
//
// Ports:
//   I_clk, I_reset        clock, asynchronous active-high reset
//   I_valid / O_ready     upstream handshake for the field set
//   I_opcode              instruction bits [6:2]; bits [1:0] are forced to 2'b11
//   I_rd, I_rs1, I_rs2    register indices
//   I_funct3, I_funct7    funct fields (funct7 used by R-type only)
//   I_imm                 immediate in decoded form
//   O_valid / I_ready     downstream handshake for O_instr / O_err
//   O_instr               encoded instruction word
//   O_err                 immediate not representable in the selected format
//
// Configuration macro: ENCODER_RANGECHECK_EN
//   defined   -> immediate range checks are built and O_err is registered
//   undefined -> O_err is tied to 0 and no check logic exists
// ---------------------------------------------------------------------------
module instr_encoder (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_valid,
    output logic        O_ready,
    input  logic [4:0]  I_opcode,
    input  logic [4:0]  I_rd,
    input  logic [4:0]  I_rs1,
    input  logic [4:0]  I_rs2,
    input  logic [2:0]  I_funct3,
    input  logic [6:0]  I_funct7,
    input  logic [31:0] I_imm,
    output logic        O_valid,
    input  logic        I_ready,
    output logic [31:0] O_instr,
    output logic        O_err
);

    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_OP     = 5'b01100;

    // Stage A: captured field set
    logic        va_q, va_d;
    logic [4:0]  a_opcode_q, a_opcode_d;
    logic [4:0]  a_rd_q, a_rd_d;
    logic [4:0]  a_rs1_q, a_rs1_d;
    logic [4:0]  a_rs2_q, a_rs2_d;
    logic [2:0]  a_funct3_q, a_funct3_d;
    logic [6:0]  a_funct7_q, a_funct7_d;
    logic [31:0] a_imm_q, a_imm_d;

    // Stage B: encoded word
    logic        vb_q, vb_d;
    logic [31:0] instr_q, instr_d;

    logic        load_a;
    logic        load_b;
    logic [31:0] enc_word;

    // A accepts whenever it is empty, or it will hand its content to B this cycle.
    assign O_ready = !va_q || !vb_q || I_ready;
    assign load_a  = I_valid && O_ready;
    assign load_b  = va_q && (!vb_q || I_ready);

    assign O_valid = vb_q;
    assign O_instr = instr_q;

    // Stage A next state: a fresh load wins over an empty-out to B.
    always_comb begin
        va_d       = va_q;
        a_opcode_d = a_opcode_q;
        a_rd_d     = a_rd_q;
        a_rs1_d    = a_rs1_q;
        a_rs2_d    = a_rs2_q;
        a_funct3_d = a_funct3_q;
        a_funct7_d = a_funct7_q;
        a_imm_d    = a_imm_q;
        if (load_a) begin
            va_d       = 1'b1;
            a_opcode_d = I_opcode;
            a_rd_d     = I_rd;
            a_rs1_d    = I_rs1;
            a_rs2_d    = I_rs2;
            a_funct3_d = I_funct3;
            a_funct7_d = I_funct7;
            a_imm_d    = I_imm;
        end else if (load_b) begin
            va_d = 1'b0;
        end
    end

    // Format-dependent packing of the stage A fields.
    always_comb begin
        enc_word      = 32'h0;
        enc_word[6:0] = {a_opcode_q, 2'b11};
        case (a_opcode_q)
            OPC_STORE: begin
                enc_word[31:25] = a_imm_q[11:5];
                enc_word[24:20] = a_rs2_q;
                enc_word[19:15] = a_rs1_q;
                enc_word[14:12] = a_funct3_q;
                enc_word[11:7]  = a_imm_q[4:0];
            end
            OPC_BRANCH: begin
                enc_word[31]    = a_imm_q[12];
                enc_word[30:25] = a_imm_q[10:5];
                enc_word[24:20] = a_rs2_q;
                enc_word[19:15] = a_rs1_q;
                enc_word[14:12] = a_funct3_q;
                enc_word[11:8]  = a_imm_q[4:1];
                enc_word[7]     = a_imm_q[11];
            end
            OPC_LUI, OPC_AUIPC: begin
                enc_word[31:12] = a_imm_q[31:12];
                enc_word[11:7]  = a_rd_q;
            end
            OPC_JAL: begin
                enc_word[31]    = a_imm_q[20];
                enc_word[30:21] = a_imm_q[10:1];
                enc_word[20]    = a_imm_q[11];
                enc_word[19:12] = a_imm_q[19:12];
                enc_word[11:7]  = a_rd_q;
            end
            OPC_OP: begin
                enc_word[31:25] = a_funct7_q;
                enc_word[24:20] = a_rs2_q;
                enc_word[19:15] = a_rs1_q;
                enc_word[14:12] = a_funct3_q;
                enc_word[11:7]  = a_rd_q;
            end
            default: begin
                enc_word[31:20] = a_imm_q[11:0];
                enc_word[19:15] = a_rs1_q;
                enc_word[14:12] = a_funct3_q;
                enc_word[11:7]  = a_rd_q;
            end
        endcase
    end

    // Stage B next state: B empties on a downstream take unless refilled from A.
    always_comb begin
        vb_d    = vb_q;
        instr_d = instr_q;
        if (load_b) begin
            vb_d    = 1'b1;
            instr_d = enc_word;
        end else if (I_ready) begin
            vb_d = 1'b0;
        end
    end

    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            va_q       <= 1'b0;
            a_opcode_q <= 5'h0;
            a_rd_q     <= 5'h0;
            a_rs1_q    <= 5'h0;
            a_rs2_q    <= 5'h0;
            a_funct3_q <= 3'h0;
            a_funct7_q <= 7'h0;
            a_imm_q    <= 32'h0;
            vb_q       <= 1'b0;
            instr_q    <= 32'h0;
        end else begin
            va_q       <= va_d;
            a_opcode_q <= a_opcode_d;
            a_rd_q     <= a_rd_d;
            a_rs1_q    <= a_rs1_d;
            a_rs2_q    <= a_rs2_d;
            a_funct3_q <= a_funct3_d;
            a_funct7_q <= a_funct7_d;
            a_imm_q    <= a_imm_d;
            vb_q       <= vb_d;
            instr_q    <= instr_d;
        end
    end

`ifdef ENCODER_RANGECHECK_EN
    logic enc_err;
    logic err_q, err_d;

    // A sign-extended field is representable only when all bits above it
    // equal its sign bit, i.e. the slice is all zeros or all ones.
    always_comb begin
        enc_err = 1'b0;
        case (a_opcode_q)
            OPC_BRANCH:         enc_err = a_imm_q[0] ||
                                          ((|a_imm_q[31:12]) && !(&a_imm_q[31:12]));
            OPC_JAL:            enc_err = a_imm_q[0] ||
                                          ((|a_imm_q[31:20]) && !(&a_imm_q[31:20]));
            OPC_LUI, OPC_AUIPC: enc_err = |a_imm_q[11:0];
            OPC_OP:             enc_err = 1'b0;
            default:            enc_err = (|a_imm_q[31:11]) && !(&a_imm_q[31:11]);
        endcase
    end

    always_comb begin
        err_d = err_q;
        if (load_b) begin
            err_d = enc_err;
        end
    end

    always_ff @(posedge I_clk or posedge I_reset) begin
        if (I_reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign O_err = err_q;
`else
    assign O_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//
// Self-checking bench for instr_encoder. The stimulus process pushes the
// hand-computed expected word into a scoreboard queue when a field set is
// accepted; an independent monitor pops and compares whenever a word leaves
// the DUT. Inputs change only on the falling clock edge (or just after the
// rising edge); outputs are sampled a little after the falling edge.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

`ifdef ENCODER_RANGECHECK_EN
    localparam logic RC_EN = 1'b1;
`else
    localparam logic RC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        I_reset;
    logic        I_valid;
    logic        O_ready;
    logic [4:0]  I_opcode;
    logic [4:0]  I_rd;
    logic [4:0]  I_rs1;
    logic [4:0]  I_rs2;
    logic [2:0]  I_funct3;
    logic [6:0]  I_funct7;
    logic [31:0] I_imm;
    logic        O_valid;
    logic        I_ready;
    logic [31:0] O_instr;
    logic        O_err;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        string       name;
    } exp_t;

    exp_t expQ[$];
    int   checks  = 0;
    int   errors  = 0;
    int   outCount = 0;

    instr_encoder dut (
        .I_clk    (clk),
        .I_reset  (I_reset),
        .I_valid  (I_valid),
        .O_ready  (O_ready),
        .I_opcode (I_opcode),
        .I_rd     (I_rd),
        .I_rs1    (I_rs1),
        .I_rs2    (I_rs2),
        .I_funct3 (I_funct3),
        .I_funct7 (I_funct7),
        .I_imm    (I_imm),
        .O_valid  (O_valid),
        .I_ready  (I_ready),
        .O_instr  (O_instr),
        .O_err    (O_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Offer one field set; wait (bounded) until accepted, then push the
    // expected result and drop I_valid just after the accepting edge.
    task automatic applyStimulus(input string name, input logic [4:0] op,
                                 input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] imm,
                                 input logic [31:0] expInstr, input logic expErr,
                                 output int stalls);
        exp_t e;
        stalls = 0;
        @(negedge clk);
        I_opcode = op;
        I_rd     = rd;
        I_rs1    = rs1;
        I_rs2    = rs2;
        I_funct3 = f3;
        I_funct7 = f7;
        I_imm    = imm;
        I_valid  = 1'b1;
        #1;
        while (!O_ready && stalls < 50) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (!O_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s accept timeout: O_ready stayed %b, required 1", name, O_ready);
            I_valid = 1'b0;
        end else begin
            e.instr = expInstr;
            e.err   = expErr;
            e.name  = name;
            expQ.push_back(e);
            @(posedge clk);
            #1;
            I_valid = 1'b0;
        end
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while (expQ.size() != 0 && n < 40) begin
            @(negedge clk);
            #3;
            n++;
        end
        checkOutput({name, " drained"}, 32'(expQ.size()), 32'd0);
    endtask

    // Monitor: a word transfers on the next rising edge when O_valid && I_ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!I_reset && O_valid && I_ready) begin
                outCount++;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected output: got %h, required no word", O_instr);
                end else begin
                    e = expQ.pop_front();
                    checkOutput({e.name, " instr"}, O_instr, e.instr);
                    checkOutput({e.name, " err"}, {31'd0, O_err}, {31'd0, e.err});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int st;
        int totalStalls;
        int outBefore;
        logic [31:0] held;

        I_reset  = 1'b1;
        I_valid  = 1'b0;
        I_ready  = 1'b1;
        I_opcode = 5'h0;
        I_rd     = 5'h0;
        I_rs1    = 5'h0;
        I_rs2    = 5'h0;
        I_funct3 = 3'h0;
        I_funct7 = 7'h0;
        I_imm    = 32'h0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset O_valid", {31'd0, O_valid}, 32'd0);
        checkOutput("reset O_instr", O_instr, 32'h0);
        checkOutput("reset O_err", {31'd0, O_err}, 32'd0);
        checkOutput("reset O_ready", {31'd0, O_ready}, 32'd1);
        @(negedge clk);
        I_reset = 1'b0;

        // ADDI with latency check: stage A after the accepting edge, B one edge later
        applyStimulus("ADDI x1,x0,5", 5'b00100, 5'd1, 5'd0, 5'd0, 3'b000, 7'h0,
                      32'd5, 32'h00500093, 1'b0, st);
        @(negedge clk);
        #1;
        checkOutput("latency O_valid +1", {31'd0, O_valid}, 32'd0);
        @(negedge clk);
        #1;
        checkOutput("latency O_valid +2", {31'd0, O_valid}, 32'd1);
        waitDrain("ADDI");

        // Back-to-back burst with I_ready=1: no stalls allowed
        totalStalls = 0;
        applyStimulus("SW x2,8(x1)", 5'b01000, 5'd0, 5'd1, 5'd2, 3'b010, 7'h0,
                      32'd8, 32'h0020A423, 1'b0, st);
        totalStalls += st;
        applyStimulus("BEQ -4", 5'b11000, 5'd0, 5'd0, 5'd0, 3'b000, 7'h0,
                      32'hFFFFFFFC, 32'hFE000EE3, 1'b0, st);
        totalStalls += st;
        applyStimulus("JAL x1 0x800", 5'b11011, 5'd1, 5'd0, 5'd0, 3'b000, 7'h0,
                      32'h00000800, 32'h001000EF, 1'b0, st);
        totalStalls += st;
        applyStimulus("LUI x5", 5'b01101, 5'd5, 5'd0, 5'd0, 3'b000, 7'h0,
                      32'h12345000, 32'h123452B7, 1'b0, st);
        totalStalls += st;
        applyStimulus("ADD x3,x1,x2", 5'b01100, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00,
                      32'hFFFFFFFF, 32'h002081B3, 1'b0, st);
        totalStalls += st;
        applyStimulus("SUB x3,x1,x2", 5'b01100, 5'd3, 5'd1, 5'd2, 3'b000, 7'h20,
                      32'h0, 32'h402081B3, 1'b0, st);
        totalStalls += st;
        applyStimulus("SW imm -2048", 5'b01000, 5'd0, 5'd0, 5'd0, 3'b010, 7'h0,
                      32'hFFFFF800, 32'h80002023, 1'b0, st);
        totalStalls += st;
        checkOutput("burst stalls", 32'(totalStalls), 32'd0);
        waitDrain("burst");

        // Range errors: the word is still emitted
        applyStimulus("ADDI imm 2048", 5'b00100, 5'd1, 5'd0, 5'd0, 3'b000, 7'h0,
                      32'd2048, 32'h80000093, RC_EN, st);
        applyStimulus("BRANCH imm 3", 5'b11000, 5'd0, 5'd0, 5'd0, 3'b000, 7'h0,
                      32'd3, 32'h00000163, RC_EN, st);
        applyStimulus("AUIPC low bits", 5'b00101, 5'd0, 5'd0, 5'd0, 3'b000, 7'h0,
                      32'h00001004, 32'h00001017, RC_EN, st);
        applyStimulus("JAL imm 2^20", 5'b11011, 5'd0, 5'd0, 5'd0, 3'b000, 7'h0,
                      32'h00100000, 32'h8000006F, RC_EN, st);
        waitDrain("errors");

        // Backpressure: two buffered, third refused, output stable, then in-order drain
        @(negedge clk);
        I_ready = 1'b0;
        outBefore = outCount;
        applyStimulus("BP ADDI x2,x0,7", 5'b00100, 5'd2, 5'd0, 5'd0, 3'b000, 7'h0,
                      32'd7, 32'h00700113, 1'b0, st);
        applyStimulus("BP LUI x5", 5'b01101, 5'd5, 5'd0, 5'd0, 3'b000, 7'h0,
                      32'h12345000, 32'h123452B7, 1'b0, st);
        @(negedge clk);
        I_opcode = 5'b00100;
        I_rd     = 5'd1;
        I_imm    = 32'd5;
        I_valid  = 1'b1;
        #1;
        checkOutput("BP third O_ready", {31'd0, O_ready}, 32'd0);
        checkOutput("BP O_valid", {31'd0, O_valid}, 32'd1);
        held = O_instr;
        @(negedge clk);
        I_valid = 1'b0;
        #1;
        checkOutput("BP O_instr stable", O_instr, held);
        checkOutput("BP O_instr head", O_instr, 32'h00700113);
        @(negedge clk);
        I_ready = 1'b1;
        waitDrain("backpressure");
        checkOutput("BP word count", 32'(outCount - outBefore), 32'd2);

        // Reset with both stages full: everything buffered is dropped
        @(negedge clk);
        I_ready = 1'b0;
        applyStimulus("RST lost 1", 5'b00100, 5'd4, 5'd0, 5'd0, 3'b000, 7'h0,
                      32'd1, 32'h00100213, 1'b0, st);
        applyStimulus("RST lost 2", 5'b00100, 5'd4, 5'd0, 5'd0, 3'b000, 7'h0,
                      32'd2, 32'h00200213, 1'b0, st);
        @(negedge clk);
        #1;
        checkOutput("full O_ready", {31'd0, O_ready}, 32'd0);
        #2;
        I_reset = 1'b1;
        #1;
        checkOutput("mid-reset O_valid", {31'd0, O_valid}, 32'd0);
        checkOutput("mid-reset O_ready", {31'd0, O_ready}, 32'd1);
        expQ.delete();
        @(negedge clk);
        I_reset = 1'b0;
        I_ready = 1'b1;
        outBefore = outCount;
        applyStimulus("post-reset ADDI", 5'b00100, 5'd1, 5'd0, 5'd0, 3'b000, 7'h0,
                      32'd5, 32'h00500093, 1'b0, st);
        waitDrain("post-reset");
        checkOutput("post-reset word count", 32'(outCount - outBefore), 32'd1);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Pipelined RISC-V RV32I instruction encoder. It is the inverse of the instruction field decoder: it accepts opcode, register indices, funct fields and a 32-bit immediate, and packs them into a 32-bit instruction word. It sits between the debug/instruction-injection logic and the fetch-side instruction mux. Valid/ready handshake on both sides; two register stages; full throughput.

## Interface
- No parameters.
- I_clk  input  1  clock; all state updates on rising edge.
- I_reset  input  1  asynchronous, active-high reset.
- I_valid  input  1  upstream field set valid.
- O_ready  output  1  encoder accepts a field set this cycle.
- I_opcode  input  5  instruction bits [6:2]; bits [1:0] are always 2'b11.
- I_rd, I_rs1, I_rs2  input  5 each  register indices.
- I_funct3  input  3  funct3.
- I_funct7  input  7  funct7, used for R-type only.
- I_imm  input  32  immediate in decoded (sign-extended, byte-offset) form.
- O_valid  output  1  O_instr / O_err valid.
- I_ready  input  1  downstream accepts output.
- O_instr  output  32  encoded instruction word.
- O_err  output  1  immediate not representable in the selected format.

## Operation
- Stage A register: holds the field set and valid bit vA. It loads when I_valid && O_ready.
- Stage B register: holds O_instr, O_err and valid bit vB (O_valid = vB). It loads the encoding of stage A when vA && (!vB || I_ready).
- O_ready = !vA || !vB || I_ready. This is a combinational path from I_ready.
- Format selection by I_opcode:
  - STORE 01000, S-type: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - BRANCH 11000, B-type: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - LUI 01101 / AUIPC 00101, U-type: [31:12]=imm[31:12].
  - JAL 11011, J-type: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - OP 01100, R-type: [31:25]=funct7.
  - All other opcodes, I-type: [31:20]=imm[11:0].
- Field placement in every format: [6:0]={opcode,2'b11}; [11:7]=rd for R/I/U/J; [14:12]=funct3 for R/I/S/B; [19:15]=rs1 for R/I/S/B; [24:20]=rs2 for R/S/B.
- Unused fields are ignored. Immediate bits outside the format are dropped.
- Error rules (compiled in by the range-check macro):
  - I/S: imm[31:11] must be all-equal.
  - B: imm[0]==0 and imm[31:12] all-equal.
  - J: imm[0]==0 and imm[31:20] all-equal.
  - U: imm[11:0]==0.
  - R: never an error.
- An error never blocks a transfer. The word is still emitted, with O_err=1.

## Timing
- Reset values: vA=0, vB=0, O_valid=0, O_instr=32'h0, O_err=0. O_ready=1 after reset.
- Latency: the accepting edge loads stage A; the next edge loads stage B, so O_valid is high 2 cycles after acceptance with no backpressure.
- Throughput: one word per cycle while I_ready=1.
- Backpressure (I_ready=0): B holds; A holds if full. At most 2 field sets are buffered, then O_ready=0.
- Simultaneous B drain and A→B load in one cycle is legal. A new input may load A in that same cycle.
- O_instr and O_err are stable while O_valid && !I_ready.
- Reset asserted mid-transfer clears both stages immediately. Buffered words are lost.

## Configuration
- ENCODER_RANGECHECK_EN:
  - Defined: the error rules above are implemented and O_err is registered in stage B.
  - Undefined: O_err is constant 0 and no check logic is synthesized.
  - Encoding is identical in both cases.

## Test plan
- ADDI x1,x0,5 (opcode 00100, rd=1, funct3=0, imm=5), I_ready=1 → O_instr=32'h00500093 two cycles after acceptance, O_err=0.
- SW x2,8(x1) (opcode 01000, rs1=1, rs2=2, funct3=010, imm=8) → 32'h0020A423. BEQ x0,x0 (opcode 11000, funct3=000, imm=-4) → 32'hFE000EE3.
- JAL x1 (opcode 11011, rd=1, imm=32'h800) → 32'h001000EF. LUI x5 (opcode 01101, rd=5, imm=32'h12345000) → 32'h123452B7.
- ADDI with imm=2048 → O_instr=32'h80000093 with O_err=1 when the macro is defined, O_err=0 when undefined. BRANCH with imm=3 → O_err=1.
- Hold I_ready=0 and offer 3 back-to-back inputs → 2 are accepted, then O_ready=0. Release I_ready → all words exit in order with no loss or duplication.
- Assert I_reset with both stages full → O_valid=0 and O_ready=1 immediately; first output after release is the next accepted input.
